// File: rtl/flag_gen.sv
// Condition-code producer: N/Z/V from ALU and multiplier results, with in-flight multiply tracking.
// Optional macro FLAG_BYPASS_EN forwards same-cycle ALU flag writes combinationally to N/Z/V.
module flag_gen #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  input  logic [WIDTH-1:0] aluResult,
  input  logic [1:0]       opClass,
  input  logic             setFlags,
  input  logic             stall,
  input  logic             flush,
  input  logic             mulStart,
  input  logic [WIDTH-1:0] mulResult,
  input  logic             mulOvfl,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             flagsValid
);

  localparam int unsigned CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sup_q;
  logic               n_q;
  logic               z_q;
  logic               v_q;
  logic               valid_q;

  logic               alu_wr;
  logic               alu_n;
  logic               alu_z;
  logic               alu_v;
  logic               alu_v_upd;
  logic               mul_last;
  logic               mul_wr;
  logic               unused_ok;

  // Only the operand sign bits take part in overflow detection.
  assign unused_ok = ^{aluA[MSB-1:0], aluB[MSB-1:0]};

  assign alu_wr = setFlags & ~stall & ~flush;
  assign alu_n  = aluResult[MSB];
  assign alu_z  = (aluResult == '0);

  always_comb begin
    alu_v     = v_q;
    alu_v_upd = 1'b0;
    unique case (opClass)
      OP_ADD: begin
        alu_v     = (aluA[MSB] == aluB[MSB]) & (aluResult[MSB] != aluA[MSB]);
        alu_v_upd = 1'b1;
      end
      OP_SUB: begin
        alu_v     = (aluA[MSB] != aluB[MSB]) & (aluResult[MSB] != aluA[MSB]);
        alu_v_upd = 1'b1;
      end
      OP_LOGIC, OP_SHIFT: begin
        alu_v     = v_q;
        alu_v_upd = 1'b0;
      end
      default: begin
        alu_v     = v_q;
        alu_v_upd = 1'b0;
      end
    endcase
  end

  // A restart or flush on the final cycle kills the old multiply; a same-cycle ALU write wins.
  assign mul_last = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(1));
  assign mul_wr   = mul_last & ~flush & ~mulStart & ~sup_q & ~alu_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sup_q   <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b1;
    end else begin
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        valid_q <= 1'b1;
      end else if (mulStart) begin
        state_q <= MUL_BUSY;
        cnt_q   <= CNT_W'(MUL_LAT);
        sup_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
          end
          MUL_BUSY: begin
            if (alu_wr) begin
              sup_q <= 1'b1;
            end
            if (mul_last) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              valid_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q - CNT_W'(1);
              valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b1;
          end
        endcase
      end

      if (mul_wr) begin
        n_q <= mulResult[MSB];
        z_q <= (mulResult == '0);
        v_q <= mulOvfl;
      end
      if (alu_wr) begin
        n_q <= alu_n;
        z_q <= alu_z;
        if (alu_v_upd) begin
          v_q <= alu_v;
        end
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign N = alu_wr ? alu_n : n_q;
  assign Z = alu_wr ? alu_z : z_q;
  assign V = (alu_wr & alu_v_upd) ? alu_v : v_q;
`else
  assign N = n_q;
  assign Z = z_q;
  assign V = v_q;
`endif

  assign flagsValid = valid_q;

endmodule

// File: tb/tb_flag_gen.sv
// Scoreboard bench for flag_gen: driver pushes expected flags from a transaction-level model,
// a negedge monitor pops and compares against the registered outputs.
module tb_flag_gen;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned MUL_LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [WIDTH-1:0] aluResult;
  logic [1:0]       opClass;
  logic             setFlags;
  logic             stall;
  logic             flush;
  logic             mulStart;
  logic [WIDTH-1:0] mulResult;
  logic             mulOvfl;
  logic             N;
  logic             Z;
  logic             V;
  logic             flagsValid;

  flag_gen #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluA       (aluA),
    .aluB       (aluB),
    .aluResult  (aluResult),
    .opClass    (opClass),
    .setFlags   (setFlags),
    .stall      (stall),
    .flush      (flush),
    .mulStart   (mulStart),
    .mulResult  (mulResult),
    .mulOvfl    (mulOvfl),
    .N          (N),
    .Z          (Z),
    .V          (V),
    .flagsValid (flagsValid)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  flags;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: flags plus at most one in-flight multiply identified by its due edge.
  bit          m_n, m_z, m_v, m_pend, m_sup;
  int unsigned m_due;

  function automatic bit signed_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input bit is_sub);
    longint sa, sb, r, hi, lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = is_sub ? sa - sb : sa + sb;
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (WIDTH - 1));
    return (r > hi) || (r < lo);
  endfunction

  task automatic step(input string name, input logic r, input logic sf, input logic st,
                      input logic fl, input logic ms, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] mr,
                      input logic mo);
    int unsigned e;
    bit          alu, done;
    exp_t        x;
    rst = r; setFlags = sf; stall = st; flush = fl; mulStart = ms; opClass = op;
    aluA = a; aluB = b; aluResult = res; mulResult = mr; mulOvfl = mo;
    e = edge_cnt + 1;
    if (r) begin
      m_n = 0; m_z = 0; m_v = 0; m_pend = 0; m_sup = 0;
    end else begin
      alu  = sf && !st && !fl;
      done = m_pend && (m_due == e) && !fl && !ms;
      if (done && !m_sup && !alu) begin
        m_z = (mr == 0);
        m_n = mr[WIDTH-1];
        m_v = mo;
      end
      if (alu) begin
        m_z = (res == 0);
        m_n = res[WIDTH-1];
        if (op == 2'b01) m_v = signed_ovf(a, b, 1'b0);
        if (op == 2'b10) m_v = signed_ovf(a, b, 1'b1);
        if (m_pend && !ms) m_sup = 1;
      end
      if (fl) m_pend = 0;
      else if (ms) begin
        m_pend = 1; m_due = e + MUL_LAT; m_sup = 0;
      end else if (done) m_pend = 0;
    end
    x.cyc = e; x.flags = {m_n, m_z, m_v, !m_pend}; x.name = name;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [WIDTH-1:0] mr, input logic mo);
    step(name, 0, 0, 0, 0, 0, 2'b00, '0, '0, 16'h1234, mr, mo);
  endtask

  // Monitor: compare every expectation whose edge has already occurred.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
        mon_x = sb_q.pop_front();
        compared++;
        if ({N, Z, V, flagsValid} !== mon_x.flags) begin
          mismatched++;
          $display("FAIL %s edge %0d: {N,Z,V,flagsValid} got %b expected %b",
                   mon_x.name, mon_x.cyc, {N, Z, V, flagsValid}, mon_x.flags);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             r, sf, st, fl, ms, mo;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, res, mr;
    int               drain;

    rst = 1; setFlags = 0; stall = 0; flush = 0; mulStart = 0; opClass = 0;
    aluA = 0; aluB = 0; aluResult = 0; mulResult = 0; mulOvfl = 0;
    @(posedge clk); #1;
    step("reset0", 1, 0, 0, 0, 0, 2'b00, '0, '0, '0, '0, 0);
    step("reset1", 1, 1, 0, 0, 1, 2'b01, 16'h7FFF, 16'h0001, 16'h8000, '0, 1);

    step("add_ovf", 0, 1, 0, 0, 0, 2'b01, 16'h7FFF, 16'h0001, 16'h8000, '0, 0);
    step("sub_zero", 0, 1, 0, 0, 0, 2'b10, 16'h0005, 16'h0005, 16'h0000, '0, 0);
    step("logic_hold_v", 0, 1, 0, 0, 0, 2'b00, 16'h0F0F, 16'hFF00, 16'h0F00, '0, 0);
    step("sub_ovf", 0, 1, 0, 0, 0, 2'b10, 16'h8000, 16'h0001, 16'h7FFF, '0, 0);
    step("sub_stalled", 0, 1, 1, 0, 0, 2'b10, 16'h0005, 16'h0005, 16'h0000, '0, 0);
    step("shift_zero", 0, 1, 0, 0, 0, 2'b11, 16'h8000, 16'h0001, 16'h0000, '0, 0);

    step("mul_start", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, '0, 1);
    idle("mul_busy1", '0, 1);
    idle("mul_busy2", '0, 1);
    idle("mul_done", '0, 1);
    idle("mul_after", 16'hFFFF, 0);

    step("mul2_start", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, '0, 0);
    idle("mul2_busy", '0, 0);
    step("mul2_alu_add", 0, 1, 0, 0, 0, 2'b01, 16'h0000, 16'h0001, 16'h0001, '0, 0);
    idle("mul2_done_sup", '0, 0);

    step("mul3_start", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, '0, 0);
    step("mul3_flush", 0, 1, 0, 1, 1, 2'b01, 16'h7FFF, 16'h7FFF, 16'hFFFE, '0, 0);
    idle("mul3_after", '0, 1);
    idle("mul3_after2", '0, 1);

    step("mul4_start", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, '0, 0);
    idle("mul4_busy", '0, 1);
    step("mul4_rst", 1, 0, 0, 0, 0, 2'b00, '0, '0, '0, '0, 1);

    step("mul5_start", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, 16'h8000, 0);
    idle("mul5_busy1", 16'h8000, 0);
    step("mul5_restart", 0, 0, 0, 0, 1, 2'b00, '0, '0, '0, 16'h8000, 0);
    idle("mul5_busy2", 16'h8000, 0);
    idle("mul5_busy3", 16'h8000, 0);
    idle("mul5_done", 16'h8000, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(63) == 0);
      fl = ($urandom_range(15) == 0);
      ms = ($urandom_range(7) == 0);
      sf = !ms && ($urandom_range(2) != 0);
      st = ($urandom_range(3) == 0);
      op = 2'($urandom_range(3));
      a  = WIDTH'($urandom);
      b  = ($urandom_range(7) == 0) ? a : WIDTH'($urandom);
      case (op)
        2'b01:   res = a + b;
        2'b10:   res = a - b;
        default: res = ($urandom_range(3) == 0) ? '0 : WIDTH'($urandom);
      endcase
      mr = ($urandom_range(3) == 0) ? '0 : WIDTH'($urandom);
      mo = 1'($urandom_range(1));
      step("random", r, sf, st, fl, ms, op, a, b, res, mr, mo);
    end

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk); #1;
      drain++;
    end
    @(negedge clk); #1;
    if (sb_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
